// File: rtl/knight_pkg.sv
// knight_pkg: shared definitions for the knight scanner sequencer.
//   state_t   - sequencer states
//   *_DEF     - default parameter values used by knight_seq / knight_tick
package knight_pkg;

  localparam int unsigned WIDTH_DEF  = 8;
  localparam int unsigned DIV_W_DEF  = 8;
  localparam int unsigned PASS_W_DEF = 4;
  localparam int unsigned DWELL_DEF  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEFT,
    ST_DWELL_L,
    ST_RIGHT,
    ST_DWELL_R,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/knight_tick.sv
// knight_tick: step-rate prescaler.
//   ck   in   clock
//   res  in   asynchronous active-high reset
//   clr  in   synchronous clear of the count (burst start)
//   div  in   terminal count; tick period is div+1 clocks
//   tick out  high while the count equals div
module knight_tick
  import knight_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             ck,
  input  logic             res,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;

  assign tick = (r_cnt == div);

  always_ff @(posedge ck or posedge res) begin
    if (res) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/knight_seq.sv
// knight_seq: knight-scanner LED sequencer with start/stop handshake.
//   ck      in   clock
//   res     in   asynchronous active-high reset
//   start   in   begin a burst (accepted in IDLE only, loses to stop)
//   stop    in   abort a running burst
//   div     in   step period = div+1 clocks, latched at start
//   passes  in   passes per burst, 0 = endless, latched at start
//   busy    out  burst in progress (start acceptance .. FINISH exit)
//   done    out  one-cycle pulse after FINISH
//   pos     out  index of the lit LED
//   out     out  one-hot LED drive while busy, 0 when idle
module knight_seq
  import knight_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned DIV_W  = DIV_W_DEF,
  parameter int unsigned PASS_W = PASS_W_DEF,
  parameter int unsigned DWELL  = DWELL_DEF
) (
  input  logic                     ck,
  input  logic                     res,
  input  logic                     start,
  input  logic                     stop,
  input  logic [DIV_W-1:0]         div,
  input  logic [PASS_W-1:0]        passes,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic [WIDTH-1:0]         out
);

  localparam int unsigned POS_W = $clog2(WIDTH);
  localparam int unsigned DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  // Shifting left from WIDTH-2 lands on the MSB; shifting right from 1 lands on the LSB.
  localparam logic [POS_W-1:0] POS_PRE_MSB = POS_W'(WIDTH - 2);
  localparam logic [POS_W-1:0] POS_PRE_LSB = POS_W'(1);
  localparam logic [DW_W-1:0]  DW_LAST     = DW_W'(DWELL - 1);
  localparam state_t           ST_AFTER_L  = (DWELL == 0) ? ST_RIGHT : ST_DWELL_L;
  localparam state_t           ST_AFTER_R  = (DWELL == 0) ? ST_LEFT  : ST_DWELL_R;

  state_t             r_state;
  state_t             w_state_nx;
  logic [WIDTH-1:0]   r_out;
  logic [POS_W-1:0]   r_pos;
  logic [PASS_W-1:0]  r_pass;
  logic [PASS_W-1:0]  r_passes;
  logic [PASS_W-1:0]  w_pass_nx;
  logic [DW_W-1:0]    r_dwell;
  logic [DIV_W-1:0]   r_div;
  logic               r_done;
  logic               w_tick;
  logic               w_accept;
  logic               w_shl;
  logic               w_shr;
  logic               w_dwell_inc;
  logic               w_dwell_clr;

  knight_tick #(.DIV_W(DIV_W)) u_tick (
    .ck   (ck),
    .res  (res),
    .clr  (w_accept),
    .div  (r_div),
    .tick (w_tick)
  );

  assign w_pass_nx = r_pass + 1'b1;

  always_ff @(posedge ck or posedge res) begin
    if (res) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_accept    = 1'b0;
    w_shl       = 1'b0;
    w_shr       = 1'b0;
    w_dwell_inc = 1'b0;
    w_dwell_clr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_accept   = 1'b1;
          w_state_nx = ST_LEFT;
        end
      end
      ST_LEFT: begin
        if (stop) begin
          w_state_nx = ST_FINISH;
        end else if (w_tick) begin
          w_shl = 1'b1;
          if (r_pos == POS_PRE_MSB) w_state_nx = ST_AFTER_L;
        end
      end
      ST_DWELL_L, ST_DWELL_R: begin
        if (stop) begin
          w_state_nx = ST_FINISH;
        end else if (w_tick) begin
          if (r_dwell == DW_LAST) begin
            w_dwell_clr = 1'b1;
            w_state_nx  = (r_state == ST_DWELL_L) ? ST_RIGHT : ST_LEFT;
          end else begin
            w_dwell_inc = 1'b1;
          end
        end
      end
      ST_RIGHT: begin
        if (stop) begin
          w_state_nx = ST_FINISH;
        end else if (w_tick) begin
          w_shr = 1'b1;
          if (r_pos == POS_PRE_LSB) begin
            if ((r_passes != '0) && (w_pass_nx == r_passes)) w_state_nx = ST_FINISH;
            else                                              w_state_nx = ST_AFTER_R;
          end
        end
      end
      ST_FINISH: w_state_nx = ST_IDLE;
      default:   w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge res) begin
    if (res) begin
      r_out    <= '0;
      r_pos    <= '0;
      r_pass   <= '0;
      r_passes <= '0;
      r_dwell  <= '0;
      r_div    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == ST_FINISH);
      if (w_accept) begin
        r_div    <= div;
        r_passes <= passes;
        r_out    <= WIDTH'(1);
        r_pos    <= '0;
        r_pass   <= '0;
        r_dwell  <= '0;
      end else if (r_state == ST_FINISH) begin
        r_out <= '0;
        r_pos <= '0;
      end else begin
        if (w_shl) begin
          r_out <= {r_out[WIDTH-2:0], 1'b0};
          r_pos <= r_pos + 1'b1;
        end
        if (w_shr) begin
          r_out <= {1'b0, r_out[WIDTH-1:1]};
          r_pos <= r_pos - 1'b1;
          if (r_pos == POS_PRE_LSB) r_pass <= w_pass_nx;
        end
        if (w_dwell_clr)      r_dwell <= '0;
        else if (w_dwell_inc) r_dwell <= r_dwell + 1'b1;
      end
    end
  end

  always_comb begin
    busy = (r_state != ST_IDLE);
    done = r_done;
    out  = r_out;
    pos  = r_pos;
  end

endmodule
